// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, flag bit positions and the
// width-independent part of the result payload. Also imported by the testbench.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_XOR     = 4'd4,
    OP_NOT     = 4'd5,
    OP_SHL     = 4'd6,
    OP_SHR     = 4'd7,
    OP_ASR     = 4'd8,
    OP_CMP     = 4'd9,
    OP_INC     = 4'd10,
    OP_DEC     = 4'd11,
    OP_MUL     = 4'd12,
    OP_ACC_ADD = 4'd13,
    OP_ACC_CLR = 4'd14,
    OP_ILLEGAL = 4'd15
  } alu_op_e;

  localparam int unsigned FLG_W = 4;
  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  // Status half of a stage-2 result; the N-bit data half is added by the user.
  typedef struct packed {
    logic [FLG_W-1:0] flags;
    logic             err;
  } alu_status_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Ports: op (opcode), a/b (operands, b doubles as shift amount), acc (current
// accumulator); res (result), flags {neg,zero,carry,ovf}, err (illegal opcode),
// acc_we (result must be written to the accumulator).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  alu_op_e          op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     acc,
  output logic [N-1:0]     res,
  output logic [FLG_W-1:0] flags,
  output logic             err,
  output logic             acc_we
);

  localparam int unsigned SHW = $clog2(N) + 1;
  localparam logic [N-1:0] N_VAL = N'(N);

  logic [N-1:0]        add_x;
  logic [N-1:0]        add_y;
  logic                add_sub;
  logic [N:0]          add_sum;
  logic                add_ovf;
  logic                sh_big;
  logic [SHW-1:0]      shamt;
  logic signed [N-1:0] asr_val;
  logic [2*N-1:0]      prod;
  logic                carry;
  logic                ovf;

  // Shared adder/subtractor; bit N is carry-out for add and borrow for sub.
  always_comb begin
    add_x   = a;
    add_y   = b;
    add_sub = 1'b0;
    case (op)
      OP_SUB, OP_CMP: add_sub = 1'b1;
      OP_INC:         add_y   = N'(1);
      OP_DEC: begin
        add_y   = N'(1);
        add_sub = 1'b1;
      end
      OP_ACC_ADD: begin
        add_x = acc;
        add_y = a;
      end
      default: ;
    endcase
    add_sum = add_sub ? ({1'b0, add_x} - {1'b0, add_y})
                      : ({1'b0, add_x} + {1'b0, add_y});
    add_ovf = add_sub ? ((add_x[N-1] != add_y[N-1]) && (add_sum[N-1] != add_x[N-1]))
                      : ((add_x[N-1] == add_y[N-1]) && (add_sum[N-1] != add_x[N-1]));
  end

  // Amounts >= N saturate; below that b always fits in SHW bits.
  assign sh_big  = (b >= N_VAL);
  assign shamt   = b[SHW-1:0];
  assign asr_val = $signed(a) >>> shamt;
  assign prod    = (2*N)'(a) * (2*N)'(b);

  // Result select.
  always_comb begin
    res    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    acc_we = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        res   = add_sum[N-1:0];
        carry = add_sum[N];
        ovf   = add_ovf;
      end
      OP_CMP: begin
        res   = a;
        carry = add_sum[N];
        ovf   = add_ovf;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: res = sh_big ? '0 : (a << shamt);
      OP_SHR: res = sh_big ? '0 : (a >> shamt);
      OP_ASR: res = sh_big ? {N{a[N-1]}} : asr_val;
      OP_MUL: begin
        res   = prod[N-1:0];
        carry = |prod[2*N-1:N];
      end
      OP_ACC_ADD: begin
        res    = add_sum[N-1:0];
        carry  = add_sum[N];
        ovf    = add_ovf;
        acc_we = 1'b1;
      end
      OP_ACC_CLR: acc_we = 1'b1;
      default:    err    = 1'b1;
    endcase
  end

  // Flag assembly.
  always_comb begin
    flags        = '0;
    flags[FLG_N] = res[N-1];
    flags[FLG_Z] = (res == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an accumulator.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with op_code, inp1,
// inp2 on the input side; out_valid/out_ready with outp, flags, err on the
// output side; acc_out shows the accumulator register.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op_code,
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] outp,
  output logic [3:0]   flags,
  output logic         err,
  output logic [N-1:0] acc_out
);

  typedef struct packed {
    logic [N-1:0] outp;
    alu_status_t  stat;
  } s2_res_t;

  logic             s1_valid;
  alu_op_e          s1_op;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic             s2_valid;
  s2_res_t          s2_q;
  logic [N-1:0]     acc_q;
  logic             s2_ready;
  logic             s1_move;
  logic [N-1:0]     core_res;
  logic [FLG_W-1:0] core_flags;
  logic             core_err;
  logic             core_acc_we;

  // Ready chaining: a stage can load when empty or when it drains this cycle.
  assign s2_ready = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign s1_move  = s1_valid && s2_ready;

  alu_core #(.N(N)) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .acc    (acc_q),
    .res    (core_res),
    .flags  (core_flags),
    .err    (core_err),
    .acc_we (core_acc_we)
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= alu_op_e'(op_code);
        s1_a  <= inp1;
        s1_b  <= inp2;
      end
    end
  end

  // Stage 2: result capture, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_q.outp       <= core_res;
        s2_q.stat.flags <= core_flags;
        s2_q.stat.err   <= core_err;
      end
    end
  end

  // Accumulator commits with the op's S1->S2 move, so the next op sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (s1_move && core_acc_we) begin
      acc_q <= core_res;
    end
  end

  assign out_valid = s2_valid;
  assign outp      = s2_q.outp;
  assign flags     = s2_q.stat.flags;
  assign err       = s2_q.stat.err;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Randomized and directed bench for alu_pipe (N=4) with a scoreboard fed by an
// arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned N = 4;
  localparam int M = 1 << N;

  typedef struct packed {
    logic [N-1:0] o;
    logic [3:0]   f;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op_code = '0;
  logic [N-1:0] inp1 = '0;
  logic [N-1:0] inp2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] outp;
  logic [3:0]   flags;
  logic         err;
  logic [N-1:0] acc_out;

  always #5 clk = ~clk;

  alu_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .inp1      (inp1),
    .inp2      (inp2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .flags     (flags),
    .err       (err),
    .acc_out   (acc_out)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_acc = 0;
  logic fired = 1'b0;
  logic hold_pending = 1'b0;
  exp_t held;
  exp_t sb[$];
  exp_t outs[$];
  int   out_cyc[$];
  int   acc_cyc[$];
  int   q_op[$];
  int   q_a[$];
  int   q_b[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= M / 2) ? x - M : x;
  endfunction

  function automatic int sovf(input int x);
    return (x > M / 2 - 1 || x < -(M / 2)) ? 1 : 0;
  endfunction

  // Reference model in plain integer arithmetic; updates m_acc for ACC ops.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t r;
    int v = 0;
    int c = 0;
    int o = 0;
    int e = 0;
    case (op)
      0:  begin o = a + b; c = (o >= M); v = sovf(sx(a) + sx(b)); end
      1, 9: begin o = a - b; c = (a < b); v = sovf(sx(a) - sx(b)); end
      2:  o = a & b;
      3:  o = a | b;
      4:  o = a ^ b;
      5:  o = ~a;
      6:  o = (b >= int'(N)) ? 0 : (a << b);
      7:  o = (b >= int'(N)) ? 0 : (a >> b);
      8:  o = (b >= int'(N)) ? ((sx(a) < 0) ? -1 : 0) : (sx(a) >>> b);
      10: begin o = a + 1; c = (o >= M); v = sovf(sx(a) + 1); end
      11: begin o = a - 1; c = (a < 1); v = sovf(sx(a) - 1); end
      12: begin o = a * b; c = (o >= M); end
      13: begin o = m_acc + a; c = (o >= M); v = sovf(sx(m_acc) + sx(a)); end
      14: o = 0;
      default: begin o = 0; e = 1; end
    endcase
    o = o & (M - 1);
    if (op == 9) o = a;
    if (op == 13) m_acc = o;
    if (op == 14) m_acc = 0;
    r.o        = N'(o);
    r.f        = '0;
    r.f[FLG_N] = (o >= M / 2);
    r.f[FLG_Z] = (o == 0);
    r.f[FLG_C] = c[0];
    r.f[FLG_V] = v[0];
    r.e        = e[0];
    return r;
  endfunction

  // One clock: observe handshakes at negedge, then step past the posedge.
  task automatic tick();
    exp_t cur;
    exp_t e;
    @(negedge clk);
    cyc++;
    fired = 1'b0;
    cur = {outp, flags, err};
    if (out_valid) begin
      if (hold_pending) check_eq("hold_stable", 32'(cur), 32'(held));
      if (out_ready) begin
        hold_pending = 1'b0;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("result", 32'(cur), 32'(e));
          outs.push_back(cur);
          out_cyc.push_back(cyc);
        end
      end else begin
        hold_pending = 1'b1;
        held = cur;
      end
    end
    if (in_valid && in_ready) begin
      fired = 1'b1;
      sb.push_back(model(int'(op_code), int'(inp1), int'(inp2)));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int op, input int a, input int b);
    q_op.push_back(op);
    q_a.push_back(a);
    q_b.push_back(b);
  endtask

  task automatic drive_head();
    in_valid = (q_op.size() > 0);
    if (in_valid) begin
      op_code = 4'(q_op[0]);
      inp1    = N'(q_a[0]);
      inp2    = N'(q_b[0]);
    end
  endtask

  task automatic pop_head();
    void'(q_op.pop_front());
    void'(q_a.pop_front());
    void'(q_b.pop_front());
  endtask

  // Issue queued ops back-to-back with out_ready=1 and drain the pipe.
  task automatic run_burst();
    int guard = 0;
    out_ready = 1'b1;
    while ((q_op.size() > 0 || sb.size() > 0) && guard < 100) begin
      drive_head();
      tick();
      if (fired) pop_head();
      guard++;
    end
    in_valid = 1'b0;
    check_eq("burst_drained", 32'(q_op.size() + sb.size()), 32'd0);
  endtask

  task automatic clear_log();
    outs.delete();
    out_cyc.delete();
    acc_cyc.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int naccept;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_outp", 32'(outp), 32'd0);
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_acc", 32'(acc_out), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Arithmetic flags + latency/throughput (4 ops back-to-back)
    clear_log();
    push(0, 7, 9);
    push(0, 7, 1);
    push(1, 2, 3);
    push(12, 5, 5);
    run_burst();
    check_eq("n_outs_arith", 32'(outs.size()), 32'd4);
    check_eq("add79_out", 32'(outs[0].o), 32'd0);
    check_eq("add79_flags", 32'(outs[0].f), 32'b0110);
    check_eq("add71_out", 32'(outs[1].o), 32'd8);
    check_eq("add71_flags", 32'(outs[1].f), 32'b1001);
    check_eq("sub23_out", 32'(outs[2].o), 32'd15);
    check_eq("sub23_flags", 32'(outs[2].f), 32'b1010);
    check_eq("mul55_out", 32'(outs[3].o), 32'd9);
    check_eq("mul55_carry", 32'(outs[3].f[FLG_C]), 32'd1);
    check_eq("first_latency", 32'(out_cyc[0] - acc_cyc[0]), 32'd2);
    for (int i = 1; i < 4; i++) begin
      check_eq("accept_b2b", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd1);
      check_eq("out_b2b", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
    end

    // Shift / illegal boundaries
    clear_log();
    push(6, 3, 5);
    push(8, 8, 4);
    push(15, 6, 7);
    run_burst();
    check_eq("shl_big", 32'(outs[0].o), 32'd0);
    check_eq("asr_big", 32'(outs[1].o), 32'd15);
    check_eq("illegal_out", 32'(outs[2].o), 32'd0);
    check_eq("illegal_err", 32'(outs[2].e), 32'd1);

    // Accumulator back-to-back
    clear_log();
    push(14, 0, 0);
    push(13, 5, 0);
    push(13, 6, 0);
    run_burst();
    check_eq("acc_clr_out", 32'(outs[0].o), 32'd0);
    check_eq("acc_add5_out", 32'(outs[1].o), 32'd5);
    check_eq("acc_add6_out", 32'(outs[2].o), 32'd11);
    check_eq("acc_out_11", 32'(acc_out), 32'd11);
    push(0, 1, 1);
    run_burst();
    check_eq("acc_untouched", 32'(acc_out), 32'd11);

    // Backpressure: two ops fill the pipe, third waits for the stall to clear
    clear_log();
    out_ready = 1'b0;
    push(0, 1, 2);
    push(4, 5, 3);
    push(3, 8, 1);
    naccept = 0;
    for (int i = 0; i < 3; i++) begin
      drive_head();
      tick();
      if (fired) begin
        pop_head();
        naccept++;
      end
    end
    check_eq("bp_accepts", 32'(naccept), 32'd2);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive_head();
      tick();
      if (fired) pop_head();
    end
    check_eq("bp_still_full", 32'(q_op.size()), 32'd1);
    out_ready = 1'b1;
    drive_head();
    tick();
    check_eq("bp_third_accept", 32'(fired), 32'd1);
    if (fired) pop_head();
    run_burst();
    check_eq("bp_n_outs", 32'(outs.size()), 32'd3);

    // Reset with two ops in flight and output stalled
    clear_log();
    out_ready = 1'b0;
    push(13, 3, 0);
    push(0, 1, 2);
    for (int i = 0; i < 2; i++) begin
      drive_head();
      tick();
      if (fired) pop_head();
    end
    in_valid = 1'b0;
    check_eq("pre_rst_acc", 32'(acc_out), 32'(m_acc));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    hold_pending = 1'b0;
    m_acc = 0;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_acc", 32'(acc_out), 32'd0);
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("no_stale_out", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      op_code   = 4'($urandom_range(15));
      inp1      = N'($urandom_range(M - 1));
      inp2      = N'($urandom_range(M - 1));
      out_ready = ($urandom_range(9) < 7);
      tick();
    end
    in_valid = 1'b0;
    run_burst();
    check_eq("rand_acc", 32'(acc_out), 32'(m_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
